data_bucket_stats: RTL
======================

Name: data_bucket_stats

Overview:
Parametrised, synthesizable multi-channel sink. It terminates NUM_CH valid/ready streams at the output of the SNN accelerator datapath and keeps per-channel transfer statistics in registers: beat count, inter-beat gaps and last data. It also generates programmable backpressure so that upstream stall handling can be exercised. It replaces simulation-only `$time`/real-based throughput measurement with cycle-exact counters that a bench or debug bus reads through a select mux.

Parameters:
- WIDTH, 12, data bits per channel
- NUM_CH, 4, number of independent input channels (1..16)
- CNT_W, 32, width of all statistic counters (saturating)
- READY_MODE, 0, backpressure mode: 0 = always ready, 1 = LFSR pseudo-random, 2 = periodic stall
- STALL_PERIOD, 4, mode 2 only: ready is low on one cycle in every STALL_PERIOD (must be ≥2)
- LFSR_SEED, 16'hACE1, mode 1 only: reset value of the LFSR (must be non-zero)

Ports:
- clk, input, 1, clock, rising edge
- rst, input, 1, asynchronous active-low reset (asserted when 0)
- r_data, input, NUM_CH*WIDTH, channel i occupies bits [i*WIDTH +: WIDTH]
- r_valid, input, NUM_CH, per-channel valid
- r_ready, output, NUM_CH, per-channel ready, registered
- clear, input, 1, synchronous statistics clear
- stat_sel, input, max(1,$clog2(NUM_CH)), channel whose statistics drive the stat_* outputs
- stat_beats, output, CNT_W, accepted beats on the selected channel
- stat_gap_sum, output, CNT_W, sum of inter-beat gaps on the selected channel, in cycles
- stat_gap_max, output, CNT_W, largest inter-beat gap on the selected channel
- stat_last_data, output, WIDTH, data of the most recent accepted beat on the selected channel
- cycle_count, output, CNT_W, free-running cycle counter since reset or clear

Behaviour:
- Transfer: a beat on channel i occurs on a rising edge where r_valid[i] and r_ready[i] are both 1. Data is always accepted and discarded; the bucket never refuses to complete a beat once ready is high.
- Reset (rst=0, asynchronous): all registers go to 0, including r_ready. The LFSR loads LFSR_SEED and the stall phase counter loads 0.
- Ready, mode 0: r_ready is all-ones from the first clock edge after rst deasserts.
- Ready, mode 1: one 16-bit Fibonacci LFSR with taps 16,14,13,11 advances every cycle. r_ready[i] is the registered value of lfsr[i mod 16] | lfsr[(i+5) mod 16], giving about 75% duty.
- Ready, mode 2: a phase counter counts 0..STALL_PERIOD-1 and wraps. r_ready is all-zeros on the cycle after phase==STALL_PERIOD-1 and all-ones otherwise.
- Valid is not required to depend on ready. r_ready never depends combinationally on r_valid.
- Per-channel gap counter: clears to 1 on each beat, increments every cycle otherwise, and saturates at all-ones.
- On a beat:
  - beats += 1
  - last_data is updated
  - if a previous beat exists since reset/clear, gap_sum += gap and gap_max = max(gap_max, gap)
  - the first beat after reset/clear adds no gap
  - back-to-back beats have gap = 1
- All counters saturate at 2^CNT_W-1 and never wrap. Sum additions saturate as well.
- clear: on the edge where clear=1, every statistic, every first-beat flag and cycle_count go to 0.
  - clear has priority over a coincident beat; that beat is accepted on the interface but not counted.
  - r_ready generation is unaffected by clear.
- cycle_count increments every cycle when not in reset or clear.
- stat_* outputs are a combinational mux of the registered statistics. If stat_sel ≥ NUM_CH, the outputs are 0.
- Latency: a beat's effect is visible on stat_* one cycle after the accepting edge.
- Channels are fully independent. Simultaneous beats on all channels are all counted in the same cycle.

Decomposition:
- Package data_bucket_pkg:
  - READY_MODE encodings (MODE_ALWAYS, MODE_LFSR, MODE_PERIODIC)
  - LFSR tap mask
  - default seed
  - a saturating-add function
- Sub-module bucket_chan_stats, instantiated NUM_CH times in a generate loop:
  - one channel's beats, gap counter, gap_sum, gap_max, last_data and first-beat flag
  - inputs: beat, data, clear
- The top level holds the ready generator, cycle_count and the stat_sel mux.

Test Plan:
- Mode 0, NUM_CH=4, channel 0 valid for 5 consecutive cycles after reset → stat_beats=5, gap_sum=4, gap_max=1, last_data equals the 5th word; channels 1..3 read 0.
- Mode 0, channel 2 single-cycle valid pulses at cycles 10, 13 and 20 → beats=3, gap_sum=10, gap_max=7.
- Mode 2, STALL_PERIOD=4, channel 1 valid held high for 8 cycles → exactly 6 beats; r_ready low on every 4th cycle.
- CNT_W=4, channel 0 valid held for 20 cycles → stat_beats=15 (saturated), cycle_count=15.
- clear asserted on the same edge as a beat after 3 prior beats → all stats 0; the next beat gives beats=1 with gap_sum=0.
- rst pulsed low mid-stream in mode 1 → r_ready is 0 immediately and asynchronously, stats are 0, and the ready sequence after release repeats exactly the post-reset sequence from LFSR_SEED.

Source files
------------

// File: rtl/data_bucket_pkg.sv
// Shared encodings and helpers for the data bucket statistics sink.
package data_bucket_pkg;

    typedef enum logic [1:0] {
        MODE_ALWAYS   = 2'd0,
        MODE_LFSR     = 2'd1,
        MODE_PERIODIC = 2'd2
    } ready_mode_e;

    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    // Saturating add for counters up to 64 bits wide; w is the counter width.
    function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                            input int unsigned w);
        logic [64:0] sum;
        logic [64:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = (65'd1 << w) - 65'd1;
        return (sum > lim) ? lim[63:0] : sum[63:0];
    endfunction

endpackage

// File: rtl/bucket_chan_stats.sv
// One channel's transfer statistics: beat count, inter-beat gaps and last data.
module bucket_chan_stats
    import data_bucket_pkg::*;
#(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             beat_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             clear_i,
    output logic [CNT_W-1:0] beats_o,
    output logic [CNT_W-1:0] gap_sum_o,
    output logic [CNT_W-1:0] gap_max_o,
    output logic [WIDTH-1:0] last_data_o
);

    logic [CNT_W-1:0] beats_q, beats_d;
    logic [CNT_W-1:0] gap_q, gap_d;
    logic [CNT_W-1:0] gap_sum_q, gap_sum_d;
    logic [CNT_W-1:0] gap_max_q, gap_max_d;
    logic [WIDTH-1:0] last_q, last_d;
    logic             seen_q, seen_d;

    always_comb begin
        beats_d   = beats_q;
        gap_sum_d = gap_sum_q;
        gap_max_d = gap_max_q;
        last_d    = last_q;
        seen_d    = seen_q;
        gap_d     = (gap_q == '1) ? gap_q : gap_q + 1'b1;
        if (clear_i) begin
            beats_d   = '0;
            gap_sum_d = '0;
            gap_max_d = '0;
            last_d    = '0;
            seen_d    = 1'b0;
            gap_d     = '0;
        end else if (beat_i) begin
            beats_d = CNT_W'(sat_add(64'(beats_q), 64'd1, CNT_W));
            last_d  = data_i;
            seen_d  = 1'b1;
            gap_d   = CNT_W'(1);
            // The gap only means something once an earlier beat exists.
            if (seen_q) begin
                gap_sum_d = CNT_W'(sat_add(64'(gap_sum_q), 64'(gap_q), CNT_W));
                if (gap_q > gap_max_q) gap_max_d = gap_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beats_q   <= '0;
            gap_q     <= '0;
            gap_sum_q <= '0;
            gap_max_q <= '0;
            last_q    <= '0;
            seen_q    <= 1'b0;
        end else begin
            beats_q   <= beats_d;
            gap_q     <= gap_d;
            gap_sum_q <= gap_sum_d;
            gap_max_q <= gap_max_d;
            last_q    <= last_d;
            seen_q    <= seen_d;
        end
    end

    assign beats_o     = beats_q;
    assign gap_sum_o   = gap_sum_q;
    assign gap_max_o   = gap_max_q;
    assign last_data_o = last_q;

endmodule

// File: rtl/data_bucket_stats.sv
// Multi-channel valid/ready sink with programmable backpressure and
// per-channel cycle-exact transfer statistics behind a select mux.
module data_bucket_stats
    import data_bucket_pkg::*;
#(
    parameter int unsigned  WIDTH        = 12,
    parameter int unsigned  NUM_CH       = 4,
    parameter int unsigned  CNT_W        = 32,
    parameter int unsigned  READY_MODE   = 0,
    parameter int unsigned  STALL_PERIOD = 4,
    parameter logic [15:0]  LFSR_SEED    = DEFAULT_SEED,
    localparam int unsigned SEL_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH*WIDTH-1:0] r_data,
    input  logic [NUM_CH-1:0]       r_valid,
    output logic [NUM_CH-1:0]       r_ready,
    input  logic                    clear,
    input  logic [SEL_W-1:0]        stat_sel,
    output logic [CNT_W-1:0]        stat_beats,
    output logic [CNT_W-1:0]        stat_gap_sum,
    output logic [CNT_W-1:0]        stat_gap_max,
    output logic [WIDTH-1:0]        stat_last_data,
    output logic [CNT_W-1:0]        cycle_count
);

    localparam ready_mode_e     MODE    = ready_mode_e'(2'(READY_MODE));
    localparam int unsigned     PH_W    = (STALL_PERIOD > 2) ? $clog2(STALL_PERIOD) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(STALL_PERIOD - 1);
    localparam int unsigned     SEL_N   = 1 << SEL_W;

    logic [NUM_CH-1:0] ready_q, ready_d;
    logic [NUM_CH-1:0] lfsr_tap;
    logic [15:0]       lfsr_q;
    logic [PH_W-1:0]   phase_q;
    logic [CNT_W-1:0]  cycle_q;

    logic [CNT_W-1:0] beats_w   [SEL_N];
    logic [CNT_W-1:0] gap_sum_w [SEL_N];
    logic [CNT_W-1:0] gap_max_w [SEL_N];
    logic [WIDTH-1:0] last_w    [SEL_N];

    for (genvar g = 0; g < NUM_CH; g++) begin : g_tap
        assign lfsr_tap[g] = lfsr_q[4'(g)] | lfsr_q[4'(g + 5)];
    end

    always_comb begin
        ready_d = '1;
        case (MODE)
            MODE_LFSR:     ready_d = lfsr_tap;
            MODE_PERIODIC: ready_d = (phase_q == PH_LAST) ? '0 : '1;
            default:       ready_d = '1;
        endcase
    end

    // Ready generation deliberately ignores clear so stall patterns stay reproducible.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_q <= '0;
            lfsr_q  <= LFSR_SEED;
            phase_q <= '0;
            cycle_q <= '0;
        end else begin
            ready_q <= ready_d;
            lfsr_q  <= {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
            phase_q <= (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
            cycle_q <= clear ? '0 : CNT_W'(sat_add(64'(cycle_q), 64'd1, CNT_W));
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
        bucket_chan_stats #(
            .WIDTH (WIDTH),
            .CNT_W (CNT_W)
        ) u_chan (
            .clk         (clk),
            .rst         (rst),
            .beat_i      (r_valid[g] & ready_q[g]),
            .data_i      (r_data[g*WIDTH +: WIDTH]),
            .clear_i     (clear),
            .beats_o     (beats_w[g]),
            .gap_sum_o   (gap_sum_w[g]),
            .gap_max_o   (gap_max_w[g]),
            .last_data_o (last_w[g])
        );
    end

    // Unpopulated select codes read as zero.
    for (genvar g = NUM_CH; g < SEL_N; g++) begin : g_pad
        assign beats_w[g]   = '0;
        assign gap_sum_w[g] = '0;
        assign gap_max_w[g] = '0;
        assign last_w[g]    = '0;
    end

    assign r_ready        = ready_q;
    assign cycle_count    = cycle_q;
    assign stat_beats     = beats_w[stat_sel];
    assign stat_gap_sum   = gap_sum_w[stat_sel];
    assign stat_gap_max   = gap_max_w[stat_sel];
    assign stat_last_data = last_w[stat_sel];

endmodule
